// File: rtl/puf_ctrl_pkg.sv
// Shared types and defaults for the arbiter-PUF evaluation sequencer.
// VOTES follows PUF_MAJORITY_VOTE_EN: 3 races per bit when defined, otherwise 1.
package puf_ctrl_pkg;

    localparam int CHAL_W_DEF     = 32;
    localparam int RESP_W_DEF     = 8;
    localparam int SETTLE_CYC_DEF = 4;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int VOTES = 3;
`else
    localparam int VOTES = 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LAUNCH = 3'd2,
        S_SETTLE = 3'd3,
        S_SAMPLE = 3'd4,
        S_DONE   = 3'd5
    } puf_state_e;

    // Bit index width; a single-bit response still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser bringing the asynchronous arbiter output into clk.
module sync_2ff (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequencer for one arbiter-PUF channel: clear, launch, settle, sample per response bit.
// Optional build macro PUF_MAJORITY_VOTE_EN races each bit three times and takes a majority.
module puf_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int CHAL_W     = CHAL_W_DEF,
    parameter int RESP_W     = RESP_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [CHAL_W-1:0] chal_in,
    output logic              busy,
    output logic [RESP_W-1:0] resp,
    output logic              resp_valid,
    output logic [CHAL_W-1:0] puf_chal,
    output logic              arb_clr,
    output logic              launch,
    input  logic              arb_q,
    output puf_state_e        dbg_state
);

    localparam int IDX_W = idx_width(RESP_W);
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_W - 1);

    // Request handshake: start is a request that is taken only when the sequencer
    // is idle (busy=0); while busy=1 start is dropped, and resp_valid marks completion.

    puf_state_e        state;
    puf_state_e        state_next;
    logic [CHAL_W-1:0] chal_lat;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic              arb_s;
    logic              last_bit;
    logic              last_race;
    logic              bit_val;
    logic [RESP_W-1:0] resp_upd;

    function automatic logic [CHAL_W-1:0] rotl(input logic [CHAL_W-1:0] v, input int n);
        logic [2*CHAL_W-1:0] d;
        d = {v, v} << (n % CHAL_W);
        return d[2*CHAL_W-1:CHAL_W];
    endfunction

    sync_2ff u_sync (
        .clk (clk),
        .clr (clr),
        .d   (arb_q),
        .q   (arb_s)
    );

    assign last_bit  = (idx == IDX_LAST);
    assign dbg_state = state;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] race;
    logic [1:0] votes;

    assign last_race = (race == 2'(VOTES - 1));
    // votes holds the ones seen in the first two races; the third decides a tie.
    assign bit_val   = (votes == 2'd2) || ((votes == 2'd1) && arb_s);

    always_ff @(posedge clk) begin
        if (clr || (state == S_IDLE)) begin
            race  <= 2'd0;
            votes <= 2'd0;
        end else if (state == S_SAMPLE) begin
            if (last_race) begin
                race  <= 2'd0;
                votes <= 2'd0;
            end else begin
                race  <= race + 2'd1;
                votes <= votes + {1'b0, arb_s};
            end
        end
    end
`else
    assign last_race = 1'b1;
    assign bit_val   = arb_s;
`endif

    always_comb begin
        resp_upd = resp;
        for (int b = 0; b < RESP_W; b++) begin
            if (idx == IDX_W'(b)) resp_upd[b] = bit_val;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_CLEAR;
            S_CLEAR:  state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_SETTLE;
            S_SETTLE: if (cnt == '0) state_next = S_SAMPLE;
            S_SAMPLE: state_next = (last_race && last_bit) ? S_DONE : S_CLEAR;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so the arbiter sees clean pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            arb_clr    <= 1'b0;
            launch     <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != S_IDLE);
            arb_clr    <= (state_next == S_CLEAR);
            launch     <= (state_next == S_LAUNCH);
            resp_valid <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            chal_lat <= '0;
            puf_chal <= '0;
            idx      <= '0;
            cnt      <= '0;
            resp     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        chal_lat <= chal_in;
                        puf_chal <= chal_in;
                        idx      <= '0;
                        resp     <= '0;
                    end
                end
                S_LAUNCH: cnt <= CNT_W'(SETTLE_CYC - 1);
                S_SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
                S_SAMPLE: begin
                    // The challenge only advances once every race of the current bit is done.
                    if (last_race) begin
                        resp <= resp_upd;
                        if (!last_bit) begin
                            idx      <= idx + 1'b1;
                            puf_chal <= rotl(chal_lat, int'(idx) + 1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: directed steps with random challenges and masks.
// Honours PUF_MAJORITY_VOTE_EN for latencies and the vote-pattern steps.
module tb_puf_eval_ctrl;
    import puf_ctrl_pkg::*;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NV = 3;
`else
    localparam int NV = 1;
`endif
    localparam int T_DONE   = NV * 8 * (3 + 4) + 1;
    localparam int T_DONE_S = NV * 1 * (3 + 3) + 1;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] chal_in;
    logic        busy;
    logic [7:0]  resp;
    logic        resp_valid;
    logic [31:0] puf_chal;
    logic        arb_clr;
    logic        launch;
    logic        arb_q;
    puf_state_e  dbg_state;

    logic        s_start;
    logic [31:0] s_chal_in;
    logic        s_busy;
    logic [0:0]  s_resp;
    logic        s_resp_valid;
    logic [31:0] s_puf_chal;
    logic        s_arb_clr;
    logic        s_launch;
    logic        s_arb_q;
    puf_state_e  s_dbg_state;

    puf_eval_ctrl u_dut (
        .clk(clk), .clr(clr), .start(start), .chal_in(chal_in), .busy(busy),
        .resp(resp), .resp_valid(resp_valid), .puf_chal(puf_chal), .arb_clr(arb_clr),
        .launch(launch), .arb_q(arb_q), .dbg_state(dbg_state)
    );

    puf_eval_ctrl #(.CHAL_W(32), .RESP_W(1), .SETTLE_CYC(3)) u_small (
        .clk(clk), .clr(clr), .start(s_start), .chal_in(s_chal_in), .busy(s_busy),
        .resp(s_resp), .resp_valid(s_resp_valid), .puf_chal(s_puf_chal), .arb_clr(s_arb_clr),
        .launch(s_launch), .arb_q(s_arb_q), .dbg_state(s_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- arbiter behaviour model ----------------
    logic [31:0] mask = 32'h1;
    logic        vote_mode = 1'b0;
    logic        vp0 = 1'b0, vp1 = 1'b0, vp2 = 1'b0;
    int          lbase = 0;
    int          clr_cnt = 0, launch_cnt = 0;

    always_comb begin
        int r;
        r = (launch_cnt - lbase + 2) % 3;
        arb_q = ^(puf_chal & mask);
        if (vote_mode) arb_q = (r == 0) ? vp0 : ((r == 1) ? vp1 : vp2);
    end
    assign s_arb_q = s_puf_chal[0];

    // ---------------- monitor ----------------
    int          order_err = 0, overlap_err = 0, last_clr_cyc = -10;
    int          rv_q[$];
    logic [7:0]  rvr_q[$];
    logic [31:0] chal_q[$];
    int          rise_q[$], fall_q[$];
    logic        busy_d = 1'b0;

    always @(negedge clk) begin
        if (arb_clr) begin
            clr_cnt      = clr_cnt + 1;
            last_clr_cyc = cyc;
            if (launch) overlap_err = overlap_err + 1;
        end
        if (launch) begin
            launch_cnt = launch_cnt + 1;
            chal_q.push_back(puf_chal);
            if (last_clr_cyc != cyc - 1) order_err = order_err + 1;
        end
        if (resp_valid) begin
            rv_q.push_back(cyc);
            rvr_q.push_back(resp);
        end
        if (busy && !busy_d) rise_q.push_back(cyc);
        if (!busy && busy_d) fall_q.push_back(cyc - 1);
        busy_d = busy;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        int k;
        k = n % 32;
        if (k == 0) return v;
        return (v << k) | (v >> (32 - k));
    endfunction

    function automatic logic [7:0] model_resp(input logic [31:0] c, input logic [31:0] m);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {^(rotl32(c, i) & m), r[7:1]};
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    int         n_assert = 0, n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    int t_acc = 0;

    task automatic go_cyc(input int k);
        while (cyc - t_acc < k) @(negedge clk);
    endtask

    task automatic start_eval(input logic [31:0] c);
        start   = 1'b1;
        chal_in = c;
        t_acc   = cyc;
        @(negedge clk);
        start   = 1'b0;
        chal_in = $urandom;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ca, cb;
        int n_rv, n_cl, n_la, n_ch, n_ri, n_fa;

        clr = 1'b1; start = 1'b0; chal_in = '0;
        s_start = 1'b0; s_chal_in = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_busy", busy, 0);
        check("rst_resp", resp, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_puf_chal", puf_chal, 0);
        check("rst_arb_clr", arb_clr, 0);
        check("rst_launch", launch, 0);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_s_busy", s_busy, 0);
        clr = 1'b0;
        repeat (2) @(negedge clk);

        // step 1: chal=1, arbiter reads bit 0 of puf_chal
        mask = 32'h1;
        n_rv = rv_q.size(); n_cl = clr_cnt; n_la = launch_cnt; n_ch = chal_q.size();
        n_ri = rise_q.size(); n_fa = fall_q.size();
        start_eval(32'h0000_0001);
        check("c1_arb_clr", arb_clr, 1);
        check("c1_state", dbg_state, S_CLEAR);
        check("c1_puf_chal", puf_chal, 32'h1);
        check("c1_busy", busy, 1);
        go_cyc(2);
        check("c2_launch", launch, 1);
        check("c2_arb_clr", arb_clr, 0);
        go_cyc(T_DONE);
        check("t1_valid", resp_valid, 1);
        check("t1_resp", resp, 8'h01);
        go_cyc(T_DONE + 1);
        check("t1_valid_pulse", resp_valid, 0);
        check("t1_busy_off", busy, 0);
        check("t1_resp_held", resp, 8'h01);
        check("t1_puf_chal_held", puf_chal, rotl32(32'h1, 7));
        go_cyc(T_DONE + 3);
        check("t1_rv_count", rv_q.size() - n_rv, 1);
        check("t1_rv_cycle", rv_q[n_rv] - t_acc, T_DONE);
        check("t1_clr_pulses", clr_cnt - n_cl, 8 * NV);
        check("t1_launch_pulses", launch_cnt - n_la, 8 * NV);
        for (int j = 0; j < 8 * NV; j++)
            check("t1_chal_seq", chal_q[n_ch + j], rotl32(32'h1, j / NV));
        check("t1_busy_rise", rise_q[n_ri] - t_acc, 1);
        check("t1_busy_fall", fall_q[n_fa] - t_acc, T_DONE);
        check("pulse_order", order_err, 0);
        check("pulse_overlap", overlap_err, 0);

        // step 2: start during an evaluation is dropped
        ca = $urandom; mask = $urandom | 32'h1;
        n_rv = rv_q.size();
        start_eval(ca);
        go_cyc(20);
        start = 1'b1; chal_in = ~ca;
        @(negedge clk);
        start = 1'b0;
        check("t2_busy_mid", busy, 1);
        go_cyc(T_DONE + 3);
        check("t2_rv_count", rv_q.size() - n_rv, 1);
        check("t2_rv_cycle", rv_q[n_rv] - t_acc, T_DONE);
        check("t2_resp", rvr_q[n_rv], model_resp(ca, mask));

        // step 3: clear mid-evaluation, then restart at cycle 33
        ca = $urandom; cb = $urandom; mask = $urandom | 32'h1;
        n_rv = rv_q.size();
        start_eval(ca);
        go_cyc(30);
        clr = 1'b1;
        go_cyc(31);
        check("t3_busy", busy, 0);
        check("t3_resp", resp, 0);
        check("t3_state", dbg_state, S_IDLE);
        check("t3_puf_chal", puf_chal, 0);
        check("t3_valid", resp_valid, 0);
        check("t3_arb_clr", arb_clr | launch, 0);
        clr = 1'b0;
        go_cyc(33);
        start = 1'b1; chal_in = cb;
        @(negedge clk);
        start = 1'b0;
        go_cyc(33 + T_DONE + 2);
        check("t3_rv_count", rv_q.size() - n_rv, 1);
        check("t3_rv_cycle", rv_q[n_rv] - t_acc, 33 + T_DONE);
        check("t3_resp", rvr_q[n_rv], model_resp(cb, mask));

        // step 4: back-to-back random evaluations at the minimum interval
        mask = $urandom | 32'h1;
        n_rv = rv_q.size();
        for (int e = 0; e < 4; e++) begin
            ca = $urandom;
            exp_q.push_back(model_resp(ca, mask));
            start_eval(ca);
            go_cyc(T_DONE);
            check("t4_valid", resp_valid, 1);
            check("t4_resp", resp, exp_q[exp_q.size() - 1]);
            go_cyc(T_DONE + 1);
            check("t4_idle", busy, 0);
        end
        go_cyc(T_DONE + 3);
        check("t4_rv_count", rv_q.size() - n_rv, 4);
        for (int e = 0; e < 4; e++) begin
            check("t4_sb_resp", rvr_q[n_rv + e], exp_q.pop_front());
            if (e > 0) check("t4_interval", rv_q[n_rv + e] - rv_q[n_rv + e - 1], T_DONE + 1);
        end

`ifdef PUF_MAJORITY_VOTE_EN
        // step 5: majority vote patterns
        vote_mode = 1'b1;
        vp0 = 1'b1; vp1 = 1'b0; vp2 = 1'b1;
        lbase = launch_cnt;
        start_eval($urandom);
        go_cyc(T_DONE);
        check("v101_valid", resp_valid, 1);
        check("v101_resp", resp, 8'hFF);
        go_cyc(T_DONE + 2);
        vp0 = 1'b0; vp1 = 1'b1; vp2 = 1'b0;
        lbase = launch_cnt;
        start_eval($urandom);
        go_cyc(T_DONE);
        check("v010_valid", resp_valid, 1);
        check("v010_resp", resp, 8'h00);
        go_cyc(T_DONE + 2);
        vote_mode = 1'b0;
`endif

        // step 6: RESP_W=1, SETTLE_CYC=3 instance, start held high for back-to-back
        ca = $urandom;
        cb = {ca[31:1] ^ $urandom_range(0, 32'h7fff_ffff), ~ca[0]};
        s_start = 1'b1; s_chal_in = ca; t_acc = cyc;
        go_cyc(1);
        s_chal_in = cb;
        check("s_c1_busy", s_busy, 1);
        go_cyc(T_DONE_S);
        check("s_valid1", s_resp_valid, 1);
        check("s_resp1", s_resp, ca[0]);
        go_cyc(T_DONE_S + 1);
        check("s_accept_state", s_dbg_state, S_IDLE);
        check("s_accept_busy", s_busy, 0);
        go_cyc(T_DONE_S + 2);
        check("s_busy2", s_busy, 1);
        check("s_puf_chal2", s_puf_chal, cb);
        s_start = 1'b0;
        go_cyc(2 * T_DONE_S + 1);
        check("s_valid2", s_resp_valid, 1);
        check("s_resp2", s_resp, cb[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
